// File: rtl/approx_mul_pipe.sv
// approx_mul_pipe: two-stage pipelined W x W unsigned multiplier built from
// four H x H quadrant products (H = W/2). Each quadrant can be made
// approximate per beat, which clears the low TRUNC bits of that product.
// Compile-time option: APPROX_MUL_STATS_EN adds an exact shadow product and
// error/operation statistics counters. When it is not defined, err_sum and
// op_cnt are tied to zero and stat_clr is ignored.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - operand beat offered
//   in_ready   - beat accepted this cycle (combinational)
//   a, b       - W-bit unsigned operands
//   mode       - per-quadrant approximate enable {HH, HL, LH, LL}
//   out_valid  - product beat offered
//   out_ready  - downstream accepts the beat
//   prod       - 2W-bit product
//   stat_clr   - synchronous clear of statistics counters
//   err_sum    - saturating sum of (exact - prod) over delivered beats
//   op_cnt     - saturating count of delivered beats
module approx_mul_pipe #(
    parameter int W     = 8,
    parameter int TRUNC = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [3:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] prod,
    input  logic           stat_clr,
    output logic [31:0]    err_sum,
    output logic [31:0]    op_cnt
);

    localparam int H = W / 2;
    localparam logic [W-1:0] TMASK = ~((W'(1) << TRUNC) - W'(1));

    function automatic logic [W-1:0] quad(input logic [H-1:0] x,
                                          input logic [H-1:0] y,
                                          input logic         approx);
        logic [W-1:0] p;
        p = W'(x) * W'(y);
        if (approx) p = p & TMASK;
        return p;
    endfunction

    logic           advance;
    logic           s1_valid;
    logic [W-1:0]   q_ll, q_lh, q_hl, q_hh;
    logic [2*W-1:0] prod_next;

    // Whole pipeline stalls as a unit whenever the output beat is blocked.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1: quadrant products, mode is consumed here and never again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            q_ll     <= '0;
            q_lh     <= '0;
            q_hl     <= '0;
            q_hh     <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                q_ll <= quad(a[H-1:0], b[H-1:0], mode[0]);
                q_lh <= quad(a[H-1:0], b[W-1:H], mode[1]);
                q_hl <= quad(a[W-1:H], b[H-1:0], mode[2]);
                q_hh <= quad(a[W-1:H], b[W-1:H], mode[3]);
            end
        end
    end

    always_comb begin
        prod_next = ((2*W)'(q_hh) << W)
                  + (((2*W)'(q_lh) + (2*W)'(q_hl)) << H)
                  + (2*W)'(q_ll);
    end

    // Stage 2: summed product; prod holds across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            prod      <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) prod <= prod_next;
        end
    end

`ifdef APPROX_MUL_STATS_EN
    localparam int EW = (2 * W > 32) ? 2 * W : 32;

    logic [2*W-1:0] s1_exact, s2_exact;
    logic [EW:0]    err_ext, err_base, err_acc;
    logic [31:0]    err_next, cnt_base, cnt_next;
    logic           deliver;

    assign deliver = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_exact <= '0;
            s2_exact <= '0;
        end else if (advance) begin
            if (in_valid) s1_exact <= (2*W)'(a) * (2*W)'(b);
            if (s1_valid) s2_exact <= s1_exact;
        end
    end

    // A clear coinciding with a delivery restarts the counters from that beat.
    always_comb begin
        err_ext  = (EW+1)'(s2_exact - prod);
        err_base = stat_clr ? '0 : (EW+1)'(err_sum);
        err_acc  = err_base + err_ext;
        err_next = (err_acc > (EW+1)'(33'h0_FFFF_FFFF)) ? '1 : err_acc[31:0];
        cnt_base = stat_clr ? '0 : op_cnt;
        cnt_next = (cnt_base == '1) ? '1 : cnt_base + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sum <= '0;
            op_cnt  <= '0;
        end else if (deliver) begin
            err_sum <= err_next;
            op_cnt  <= cnt_next;
        end else if (stat_clr) begin
            err_sum <= '0;
            op_cnt  <= '0;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign err_sum = '0;
    assign op_cnt  = '0;
`endif

endmodule
